// File: rtl/modacc_pkg.sv
// Shared constants and types for the modulus term accumulator: operand count,
// output width derivation and the redundant (sum, carry) pair layout.
package modacc_pkg;

    localparam int NUM_TERMS    = 7;
    localparam int NUM_OPERANDS = 8;

    // Eight operands need log2(8) = 3 extra bits to hold their exact sum.
    function automatic int out_width(input int modulus_width);
        return modulus_width + 3;
    endfunction

    localparam int DEFAULT_MODULUS_WIDTH = 1024;
    localparam int DEFAULT_OUT_WIDTH     = out_width(DEFAULT_MODULUS_WIDTH);

    typedef struct packed {
        logic [DEFAULT_OUT_WIDTH-1:0] sum;
        logic [DEFAULT_OUT_WIDTH-1:0] carry;
    } redundant_pair_t;

endpackage

// File: rtl/compressor_4to2.sv
// 4:2 carry-save compressor built from two chained 3:2 layers; each carry
// vector is shifted left by one and truncated to WIDTH (sum kept mod 2^WIDTH).
module compressor_4to2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] m1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] m2;

    always_comb begin
        s1    = in0 ^ in1 ^ in2;
        m1    = (in0 & in1) | (in0 & in2) | (in1 & in2);
        c1    = {m1[WIDTH-2:0], 1'b0};
        sum   = s1 ^ c1 ^ in3;
        m2    = (s1 & c1) | (s1 & in3) | (c1 & in3);
        carry = {m2[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/modulus_term_accumulator.sv
// Two-stage carry-save accumulator of lo_residue plus seven moduli terms.
// Define MODACC_FINAL_CPA_EN to add a registered carry-propagate third stage.
module modulus_term_accumulator
    import modacc_pkg::*;
#(
    parameter int MODULUS_WIDTH = 1024,
    parameter int NUM_TERMS     = 7,
    parameter int OUT_WIDTH     = out_width(MODULUS_WIDTH)
) (
    input  logic                     clk_phase,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic [MODULUS_WIDTH-1:0] lo_residue,
    input  logic [MODULUS_WIDTH-1:0] moduli_terms [NUM_TERMS],
    output logic                     out_valid,
    output logic [OUT_WIDTH-1:0]     out_sum,
    output logic [OUT_WIDTH-1:0]     out_carry
);

    logic [OUT_WIDTH-1:0] operand_p0 [NUM_OPERANDS];
    logic [OUT_WIDTH-1:0] sum_a_p0, carry_a_p0, sum_b_p0, carry_b_p0;
    logic [OUT_WIDTH-1:0] sum_a_p1, carry_a_p1, sum_b_p1, carry_b_p1;
    logic [OUT_WIDTH-1:0] red_sum_p1, red_carry_p1;
    logic [OUT_WIDTH-1:0] sum_p2, carry_p2;
    logic                 vld_p1, vld_p2;

    always_comb begin
        operand_p0[0] = OUT_WIDTH'(lo_residue);
        for (int k = 0; k < NUM_OPERANDS - 1; k++) begin
            operand_p0[k+1] = OUT_WIDTH'(moduli_terms[k]);
        end
    end

    compressor_4to2 #(.WIDTH(OUT_WIDTH)) u_comp_a (
        .in0(operand_p0[0]), .in1(operand_p0[1]), .in2(operand_p0[2]), .in3(operand_p0[3]),
        .sum(sum_a_p0), .carry(carry_a_p0)
    );

    compressor_4to2 #(.WIDTH(OUT_WIDTH)) u_comp_b (
        .in0(operand_p0[4]), .in1(operand_p0[5]), .in2(operand_p0[6]), .in3(operand_p0[7]),
        .sum(sum_b_p0), .carry(carry_b_p0)
    );

    // Stage 1 boundary: four partial vectors from the two input compressors.
    always_ff @(posedge clk_phase or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            sum_a_p1   <= '0;
            carry_a_p1 <= '0;
            sum_b_p1   <= '0;
            carry_b_p1 <= '0;
        end else if (ce) begin
            vld_p1     <= in_valid;
            sum_a_p1   <= sum_a_p0;
            carry_a_p1 <= carry_a_p0;
            sum_b_p1   <= sum_b_p0;
            carry_b_p1 <= carry_b_p0;
        end
    end

    compressor_4to2 #(.WIDTH(OUT_WIDTH)) u_comp_final (
        .in0(sum_a_p1), .in1(carry_a_p1), .in2(sum_b_p1), .in3(carry_b_p1),
        .sum(red_sum_p1), .carry(red_carry_p1)
    );

    // Stage 2 boundary: redundant (sum, carry) pair.
    always_ff @(posedge clk_phase or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            sum_p2   <= '0;
            carry_p2 <= '0;
        end else if (ce) begin
            vld_p2   <= vld_p1;
            sum_p2   <= red_sum_p1;
            carry_p2 <= red_carry_p1;
        end
    end

`ifdef MODACC_FINAL_CPA_EN
    logic [OUT_WIDTH-1:0] sum_p3;
    logic                 vld_p3;

    // Stage 3 boundary: fully resolved sum; the true total fits OUT_WIDTH.
    always_ff @(posedge clk_phase or negedge rst_n) begin
        if (!rst_n) begin
            vld_p3 <= 1'b0;
            sum_p3 <= '0;
        end else if (ce) begin
            vld_p3 <= vld_p2;
            sum_p3 <= sum_p2 + carry_p2;
        end
    end

    assign out_valid = vld_p3;
    assign out_sum   = sum_p3;
    assign out_carry = '0;
`else
    assign out_valid = vld_p2;
    assign out_sum   = sum_p2;
    assign out_carry = carry_p2;
`endif

endmodule

// File: tb/tb_modulus_term_accumulator.sv
// Directed bench for modulus_term_accumulator: table of vectors plus reset,
// stall and mid-stream reset sequences; reconstructs sum+carry mod 2^OUT_WIDTH.
module tb_modulus_term_accumulator;
    import modacc_pkg::*;

    localparam int MW = 1024;
    localparam int OW = MW + 3;
`ifdef MODACC_FINAL_CPA_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int N = 17;

    typedef struct {
        logic          v;
        logic [MW-1:0] lo;
        logic [MW-1:0] t [7];
        logic [OW-1:0] exp;
    } vec_t;

    logic          clk_phase;
    logic          rst_n;
    logic          ce;
    logic          in_valid;
    logic [MW-1:0] lo_residue;
    logic [MW-1:0] terms [7];
    logic          out_valid;
    logic [OW-1:0] out_sum;
    logic [OW-1:0] out_carry;

    int total = 0;
    int bad   = 0;
    vec_t tbl [N];
    logic [OW-1:0] exp_q [$];
    int got_count;
    redundant_pair_t snap;
    logic snap_valid;

    modulus_term_accumulator #(.MODULUS_WIDTH(MW), .NUM_TERMS(7), .OUT_WIDTH(OW)) dut (
        .clk_phase(clk_phase), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .lo_residue(lo_residue), .moduli_terms(terms),
        .out_valid(out_valid), .out_sum(out_sum), .out_carry(out_carry)
    );

    initial begin
        clk_phase = 1'b0;
        forever #5 clk_phase = ~clk_phase;
    end

    function automatic logic [OW-1:0] recon();
        return out_sum + out_carry;
    endfunction

    function automatic logic [OW-1:0] ref_sum();
        logic [OW-1:0] s;
        s = OW'(lo_residue);
        for (int k = 0; k < 7; k++) s = s + OW'(terms[k]);
        return s;
    endfunction

    function automatic logic [MW-1:0] rand_word();
        logic [MW-1:0] r;
        for (int k = 0; k < MW / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_vec(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h..%h required=%h..%h", nm, got[OW-1:OW-32], got[63:0],
                     exp[OW-1:OW-32], exp[63:0]);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b required=%b", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_phase);
        #1;
    endtask

    task automatic drive_zero(input logic v);
        in_valid   = v;
        lo_residue = '0;
        for (int k = 0; k < 7; k++) terms[k] = '0;
    endtask

    task automatic drive_rand(input logic v, output logic [OW-1:0] e);
        in_valid   = v;
        lo_residue = rand_word();
        for (int k = 0; k < 7; k++) terms[k] = rand_word();
        e = ref_sum();
    endtask

    task automatic drive_tbl(input int i);
        in_valid   = tbl[i].v;
        lo_residue = tbl[i].lo;
        for (int k = 0; k < 7; k++) terms[k] = tbl[i].t[k];
    endtask

    // Advances one edge; a result is counted only when the edge had ce=1.
    task automatic step_mon();
        logic [OW-1:0] e;
        step();
        if (ce && out_valid) begin
            got_count++;
            if (exp_q.size() == 0) begin
                check_bit("stall_extra_result", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_vec($sformatf("stall_result%0d", got_count), recon(), e);
            end
        end
    endtask

    initial begin
        logic [OW-1:0] e;

        // Vector table with hand-computed exact sums.
        for (int i = 0; i < N; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].lo  = '0;
            for (int k = 0; k < 7; k++) tbl[i].t[k] = '0;
            tbl[i].exp = '0;
        end
        tbl[0].lo = '1;
        for (int k = 0; k < 7; k++) tbl[0].t[k] = '1;
        tbl[0].exp = {{MW{1'b1}}, 3'b000};
        for (int k = 0; k < 7; k++) begin
            tbl[k+1].t[k] = MW'(1);
            tbl[k+1].exp  = OW'(1);
        end
        tbl[8].lo  = MW'(1);
        tbl[8].exp = OW'(1);
        tbl[9].lo   = MW'(5);
        tbl[9].t[0] = MW'(3);
        tbl[9].t[6] = MW'(1) << (MW - 1);
        tbl[9].exp  = (OW'(1) << (MW - 1)) + OW'(8);
        tbl[10].v    = 1'b0;
        tbl[10].lo   = '1;
        tbl[10].t[2] = MW'(77);
        tbl[11].lo   = '1;
        tbl[11].t[3] = MW'(1);
        tbl[11].exp  = OW'(1) << MW;
        for (int i = 12; i < 17; i++) begin
            tbl[i].lo   = MW'(3 * i);
            tbl[i].t[1] = MW'(i);
            tbl[i].exp  = OW'(4 * i);
        end
        tbl[13].v = 1'b0;
        tbl[16].v = 1'b0;

        // Reset held with live inputs and ce=1.
        rst_n = 1'b0;
        ce    = 1'b1;
        drive_rand(1'b1, e);
        repeat (3) begin
            step();
            drive_rand(1'b1, e);
        end
        check_bit("reset_valid", out_valid, 1'b0);
        check_vec("reset_sum", out_sum, '0);
        check_vec("reset_carry", out_carry, '0);

        // First vector after release appears exactly LAT edges later.
        rst_n = 1'b1;
        drive_rand(1'b1, e);
        step();
        drive_zero(1'b0);
        check_bit("first_early_valid", out_valid, 1'b0);
        repeat (LAT - 1) step();
        check_bit("first_latency_valid", out_valid, 1'b1);
        check_vec("first_sum", recon(), e);
        step();
        check_bit("first_single_result", out_valid, 1'b0);
        repeat (LAT) step();

        // Table stream, including the 1,0,1,1,0 bubble pattern.
        for (int i = 0; i < N + LAT - 1; i++) begin
            if (i < N) drive_tbl(i);
            else drive_zero(1'b0);
            step();
            if (i - (LAT - 1) >= 0 && i - (LAT - 1) < N) begin
                int j;
                j = i - (LAT - 1);
                check_bit($sformatf("tbl%0d_valid", j), out_valid, tbl[j].v);
                if (tbl[j].v) check_vec($sformatf("tbl%0d_sum", j), recon(), tbl[j].exp);
`ifdef MODACC_FINAL_CPA_EN
                if (tbl[j].v) check_vec($sformatf("tbl%0d_carry_zero", j), out_carry, '0);
`endif
            end
        end
        drive_zero(1'b0);
        repeat (LAT) step();

        // Stall: 4 random vectors with a 5-cycle ce=0 gap mid-stream.
        got_count = 0;
        drive_rand(1'b1, e); exp_q.push_back(e); step_mon();
        drive_rand(1'b1, e); exp_q.push_back(e); step_mon();
        snap.sum   = out_sum;
        snap.carry = out_carry;
        snap_valid = out_valid;
        ce = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive_rand(logic'(c & 1), e);
            step();
            check_bit($sformatf("stall%0d_valid_frozen", c), out_valid, snap_valid);
            check_vec($sformatf("stall%0d_sum_frozen", c), out_sum, snap.sum);
            check_vec($sformatf("stall%0d_carry_frozen", c), out_carry, snap.carry);
        end
        ce = 1'b1;
        drive_rand(1'b1, e); exp_q.push_back(e); step_mon();
        drive_rand(1'b1, e); exp_q.push_back(e); step_mon();
        drive_zero(1'b0);
        repeat (LAT + 1) step_mon();
        total++;
        if (got_count != 4) begin
            bad++;
            $display("FAIL stall_result_count got=%0d required=4", got_count);
        end

        // Asynchronous reset with two results in flight.
        drive_rand(1'b1, e); step();
        drive_rand(1'b1, e); step();
        drive_zero(1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_bit("midreset_valid", out_valid, 1'b0);
        check_vec("midreset_sum", out_sum, '0);
        check_vec("midreset_carry", out_carry, '0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            check_bit($sformatf("post_reset%0d_valid", c), out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modulus_term_accumulator.md
# modulus_term_accumulator

Pipelined carry-save accumulator directly downstream of the modulus chunk. Each accepted cycle it sums the seven moduli terms with the low residue of the square into a redundant (sum, carry) pair that represents the partially reduced result. It gives the reduction path a fixed, stallable latency and hands the pair to the next squaring iteration or to the optional final carry-propagate stage.

## Interface
Parameters:
- MODULUS_WIDTH, 1024, width of each moduli term and of the low residue
- NUM_TERMS, 7, number of moduli terms; fixed at 7, other values unsupported
- OUT_WIDTH, MODULUS_WIDTH+3, width of the output vectors; holds the sum of 8 MODULUS_WIDTH-bit values

Ports:
- clk_phase  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; low freezes the entire pipeline
- in_valid  in  1  qualifies lo_residue and all moduli_terms in the same cycle
- lo_residue  in  MODULUS_WIDTH  low half of the square
- moduli_terms  in  MODULUS_WIDTH x 7 (unpacked [7])  moduli terms, already time-aligned by the caller
- out_valid  out  1  out_sum and out_carry are valid
- out_sum  out  OUT_WIDTH  redundant sum vector
- out_carry  out  OUT_WIDTH  redundant carry vector, already left-aligned (weight-correct)

## Operation
- Eight operands (lo_residue and terms 0..6) are zero-extended to OUT_WIDTH.
- Stage 1: two 4:2 compressors reduce operands {0-3} and {4-7} to four vectors, which are registered.
- Stage 2: one 4:2 compressor reduces the four vectors to out_sum/out_carry, which are registered.
- A 3:2 carry output is shifted left by 1, and bit OUT_WIDTH is discarded. This is lossless: the true sum is below 2^OUT_WIDTH, so out_sum + out_carry mod 2^OUT_WIDTH equals the exact sum.
- The valid bit travels with the data through each stage. A register loads only when ce=1.
- Data registers load regardless of in_valid, so there is no data gating. Consumers must qualify data with out_valid.
- There is no backpressure input; the consumer must accept every out_valid cycle.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_sum=0, out_carry=0, and all stage registers are 0.
- Latency: inputs sampled at edge N with ce=1 appear at the outputs after edge N+1 (2 ce-qualified edges). The macro adds one more edge.
- Throughput: 1 result per ce-qualified cycle.
- ce=0: all registers, including valid bits, hold their values. in_valid is ignored, and the outputs stay stable for any number of cycles.
- in_valid=0 with ce=1: a bubble propagates, and out_valid drops 2 edges later.
- Reset asserted mid-stream: in-flight results are discarded, and out_valid is 0 from the asserting edge onward.
- Reset deassertion: the first capture happens on the first rising edge with rst_n=1 and ce=1.
- Simultaneous ce=1 and reset: reset wins.

## Configuration
- MODACC_FINAL_CPA_EN defined: adds stage 3, a registered full adder. In this mode:
  - out_sum = out_sum_s2 + out_carry_s2, truncated to OUT_WIDTH;
  - out_carry is forced to 0;
  - latency is 3 edges;
  - stage 3 obeys ce and reset like the other stages.
- Undefined: 2-stage redundant output as described above, with no carry-propagate adder in the block.

## Structure
- Package modacc_pkg:
  - NUM_TERMS = 7 and NUM_OPERANDS = 8 constants;
  - a function for the OUT_WIDTH computation;
  - a typedef for the redundant pair struct {sum, carry}.
- Sub-module compressor_4to2, parameterised by width, built from two chained 3:2 carry-save layers with internal shift/truncate. It is instantiated 3 times.
- The top level contains only the operand extension, stage registers, valid pipeline and the optional CPA stage.

## Test plan
- Reset: hold rst_n=0 with random inputs and ce=1 → out_valid=0, out_sum=0, out_carry=0. Release, apply one valid vector → out_valid=1 exactly 2 edges later (3 with the macro).
- All-ones overflow: every operand = 2^MODULUS_WIDTH-1 → out_sum+out_carry mod 2^OUT_WIDTH = 8·(2^1024−1) = 2^1027−8, with no lost carry.
- Single-term sweep: only moduli_terms[k]=1 (others 0) for k=0..6, then only lo_residue=1 → the reconstructed sum is 1 for each.
- Stall: stream 4 random vectors; drop ce for 5 cycles mid-stream with in_valid toggling → outputs are frozen during the stall, and exactly 4 results arrive in order with values matching the reference model.
- Bubbles: in_valid pattern 1,0,1,1,0 with ce=1 → out_valid shows the same pattern delayed by the latency, and sums match.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 2 results in flight → out_valid drops immediately, and no stale result appears after release.
